// File: rtl/audio_in_pkg.sv
// Shared types and constants for the codec ADC I2S receiver.
package audio_in_pkg;

  // Default sample width; must match the downstream PIO input width
  localparam int DEFAULT_DATA_W = 16;

  // Channel encoding follows the ADCLRCK level: low = left, high = right
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Receiver word-framing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/audio_in_sync_edge.sv
// Multi-flop synchroniser for one asynchronous codec pin, followed by an
// edge-detect flop. The level output is delayed so it lines up with the
// registered rise/any-edge pulses.
module audio_in_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic any_edge
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;

  // Shift the pin through the synchroniser chain; the last stage feeds the edge flop
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
    level_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and edge-detect registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

  generate
    if (EDGE_EN) begin : g_edge
      logic rise_q, rise_d;
      logic edge_q, edge_d;

      // Compare the newest synchronised value against the edge flop
      always_comb begin
        rise_d = sync_q[SYNC_STAGES-1] & ~level_q;
        edge_d = sync_q[SYNC_STAGES-1] ^ level_q;
      end

      // Register pulses so they coincide with the delayed level output
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rise_q <= 1'b0;
          edge_q <= 1'b0;
        end else begin
          rise_q <= rise_d;
          edge_q <= edge_d;
        end
      end

      assign rise     = rise_q;
      assign any_edge = edge_q;
    end else begin : g_no_edge
      assign rise     = 1'b0;
      assign any_edge = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/nios_system_audio_in_i2s_rx.sv
// Codec ADC I2S receiver feeding the Avalon PIO input port.
// Build option: define AUDIO_IN_MONO_MIX_EN to drive out_port with the
// average (L + R) >>> 1 instead of the raw left sample.
module nios_system_audio_in_i2s_rx
  import audio_in_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              aud_bclk,
  input  logic              aud_adclrck,
  input  logic              aud_adcdat,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] right_sample,
  output logic              sample_valid,
  output logic              frame_err
);

  localparam int             CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic bclk_rise, lr_edge, lr_level, dat_level;
  logic unused_bclk_level, unused_bclk_edge, unused_lr_rise;
  logic unused_dat_rise, unused_dat_edge;

  audio_in_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_bclk (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (aud_bclk),
    .level    (unused_bclk_level),
    .rise     (bclk_rise),
    .any_edge (unused_bclk_edge)
  );

  audio_in_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_lrck (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (aud_adclrck),
    .level    (lr_level),
    .rise     (unused_lr_rise),
    .any_edge (lr_edge)
  );

  audio_in_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_dat (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (aud_adcdat),
    .level    (dat_level),
    .rise     (unused_dat_rise),
    .any_edge (unused_dat_edge)
  );

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ch_q, ch_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic              have_left_q, have_left_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] rs_q, rs_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] out_word;

`ifdef AUDIO_IN_MONO_MIX_EN
  logic signed [DATA_W:0] mix_sum;
  assign mix_sum  = $signed({left_q[DATA_W-1], left_q}) + $signed({right_q[DATA_W-1], right_q});
  assign out_word = DATA_W'(mix_sum >>> 1);
`else
  assign out_word = left_q;
`endif

  // Word framing FSM plus holding registers and output publication
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    count_d     = count_q;
    ch_d        = ch_q;
    left_d      = left_q;
    right_d     = right_q;
    have_left_d = have_left_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    out_d       = out_q;
    rs_d        = rs_q;
    valid_d     = 1'b0;

    if (done_q) begin
      out_d   = out_word;
      rs_d    = right_q;
      valid_d = 1'b1;
    end

    if (lr_edge) begin
      // A new channel word starts; anything partial is thrown away. A
      // coincident bit clock rise is taken as that word's delay bit.
      if (state_q == SKIP || state_q == SHIFT) begin
        err_d       = 1'b1;
        have_left_d = 1'b0;
      end
      ch_d    = lr_level;
      shift_d = '0;
      count_d = '0;
      state_d = bclk_rise ? SHIFT : SKIP;
    end else begin
      case (state_q)
        IDLE: begin
        end
        SKIP: begin
          if (bclk_rise) begin
            state_d = SHIFT;
            count_d = '0;
          end
        end
        SHIFT: begin
          if (bclk_rise) begin
            shift_d = {shift_q[DATA_W-2:0], dat_level};
            if (count_q == LAST_BIT) begin
              state_d = HOLD;
              count_d = '0;
              if (ch_q == CH_LEFT) begin
                left_d      = shift_d;
                have_left_d = 1'b1;
              end else begin
                right_d     = shift_d;
                done_d      = have_left_q;
                have_left_d = 1'b0;
              end
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      count_q     <= '0;
      ch_q        <= CH_LEFT;
      left_q      <= '0;
      right_q     <= '0;
      have_left_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_q       <= '0;
      rs_q        <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      ch_q        <= ch_d;
      left_q      <= left_d;
      right_q     <= right_d;
      have_left_q <= have_left_d;
      done_q      <= done_d;
      err_q       <= err_d;
      out_q       <= out_d;
      rs_q        <= rs_d;
      valid_q     <= valid_d;
    end
  end

  assign out_port     = out_q;
  assign right_sample = rs_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_nios_system_audio_in_i2s_rx.sv
// Self-checking bench for the codec ADC I2S receiver.
module tb_nios_system_audio_in_i2s_rx;
  import audio_in_pkg::*;

  localparam int DATA_W      = 16;
  localparam int SYNC_STAGES = 2;
  localparam int LATENCY     = SYNC_STAGES + 3;
  localparam int CLK_PERIOD  = 10;
  localparam int BCLK_HALF   = 4;
  localparam int CLEAN_BCLKS = DATA_W + 1;
  localparam int PAD_BCLKS   = 24;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              aud_bclk = 1'b0;
  logic              aud_adclrck = 1'b0;
  logic              aud_adcdat = 1'b0;
  logic [DATA_W-1:0] out_port;
  logic [DATA_W-1:0] right_sample;
  logic              sample_valid;
  logic              frame_err;

  nios_system_audio_in_i2s_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .aud_bclk     (aud_bclk),
    .aud_adclrck  (aud_adclrck),
    .aud_adcdat   (aud_adcdat),
    .out_port     (out_port),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  always #(CLK_PERIOD / 2) clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } frame_t;

  frame_t            sb_q[$];
  logic [DATA_W-1:0] obs_left  [0:63];
  logic [DATA_W-1:0] obs_right [0:63];
  int                obs_lat   [0:63];
  int                valid_seen = 0;
  int                err_seen = 0;
  int                dbl_seen = 0;
  logic              valid_prev = 1'b0;
  time               last_rise_t = 0;

  int                compared = 0;
  int                mismatched = 0;
  int                rd_idx = 0;
  int                exp_err = 0;
  logic [DATA_W-1:0] held_out = '0;
  logic [DATA_W-1:0] held_right = '0;

  // Capture every output strobe with its data and latency from the last right bit
  always @(negedge clk) begin
    if (sample_valid) begin
      if (valid_seen < 64) begin
        obs_left[valid_seen]  <= out_port;
        obs_right[valid_seen] <= right_sample;
        obs_lat[valid_seen]   <= int'(($time - last_rise_t) / CLK_PERIOD);
      end
      valid_seen <= valid_seen + 1;
      if (valid_prev) dbl_seen <= dbl_seen + 1;
    end
    if (frame_err) err_seen <= err_seen + 1;
    valid_prev <= sample_valid;
  end

  // Hard stop in case the stimulus itself stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

`ifdef AUDIO_IN_MONO_MIX_EN
  function automatic logic [DATA_W-1:0] mix(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    logic signed [DATA_W:0] s;
    s = $signed({l[DATA_W-1], l}) + $signed({r[DATA_W-1], r});
    return s[DATA_W:1];
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bclk_cycle(input logic d, input logic mark);
    aud_bclk   = 1'b0;
    aud_adcdat = d;
    repeat (BCLK_HALF) @(negedge clk);
    aud_bclk = 1'b1;
    if (mark) last_rise_t = $time;
    repeat (BCLK_HALF) @(negedge clk);
  endtask

  // One channel slot: delay bit, nbits of data MSB first, then pad bits of 1
  task automatic send_channel(input logic lr, input logic [DATA_W-1:0] word,
                              input int nbits, input int total, input logic mark_last);
    aud_adclrck = lr;
    bclk_cycle(1'b0, 1'b0);
    for (int i = 0; i < total - 1; i++) begin
      if (i < nbits) bclk_cycle(word[DATA_W-1-i], mark_last && (i == nbits - 1));
      else           bclk_cycle(1'b1, 1'b0);
    end
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                               input int bclks, input bit expect_valid);
    frame_t e;
    if (expect_valid) begin
`ifdef AUDIO_IN_MONO_MIX_EN
      e.left = mix(l, r);
`else
      e.left = l;
`endif
      e.right = r;
      sb_q.push_back(e);
      held_out   = e.left;
      held_right = r;
    end
    send_channel(CH_LEFT, l, DATA_W, bclks, 1'b0);
    send_channel(CH_RIGHT, r, DATA_W, bclks, 1'b1);
  endtask

  task automatic checkOutput(input string tag);
    frame_t e;
    int     waited;
    while (sb_q.size() != 0) begin
      waited = 0;
      while (valid_seen <= rd_idx && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      e = sb_q.pop_front();
      chk({tag, "_valid_seen"}, 32'(valid_seen > rd_idx), 32'd1);
      if (valid_seen > rd_idx) begin
        chk({tag, "_out_port"}, 32'(obs_left[rd_idx]), 32'(e.left));
        chk({tag, "_right_sample"}, 32'(obs_right[rd_idx]), 32'(e.right));
        chk({tag, "_latency"}, 32'(obs_lat[rd_idx]), 32'(LATENCY));
        rd_idx++;
      end
    end
    repeat (3) @(negedge clk);
    chk({tag, "_no_extra_valid"}, 32'(valid_seen), 32'(rd_idx));
    chk({tag, "_held_out"}, 32'(out_port), 32'(held_out));
    chk({tag, "_held_right"}, 32'(right_sample), 32'(held_right));
  endtask

  // Directed sequence
  initial begin
    @(negedge clk);

    // Reset held while the codec toggles
    send_channel(CH_LEFT, 16'hA5A5, DATA_W, CLEAN_BCLKS, 1'b0);
    send_channel(CH_RIGHT, 16'h5A5A, DATA_W, CLEAN_BCLKS, 1'b0);
    chk("reset_out_port", 32'(out_port), 32'h0);
    chk("reset_right_sample", 32'(right_sample), 32'h0);
    chk("reset_valid_pulses", 32'(valid_seen), 32'd0);
    chk("reset_err_pulses", 32'(err_seen), 32'd0);
    aud_adclrck = 1'b0;
    aud_bclk    = 1'b0;
    aud_adcdat  = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Warm-up frame: left has no preceding edge, right lacks a left partner
    applyStimulus(16'h1111, 16'h2222, CLEAN_BCLKS, 1'b0);
    checkOutput("warmup");

    // Clean frame
    applyStimulus(16'h1234, 16'hABCD, CLEAN_BCLKS, 1'b1);
    checkOutput("clean");

    // Truncated left word: ten bits then the channel flips
    $display("[TB] truncated left word");
    send_channel(CH_LEFT, 16'hDEAD, 10, 11, 1'b0);
    exp_err++;
    send_channel(CH_RIGHT, 16'h5A5A, DATA_W, CLEAN_BCLKS, 1'b1);
    repeat (10) @(negedge clk);
    chk("trunc_err_pulses", 32'(err_seen), 32'(exp_err));
    checkOutput("trunc");
    applyStimulus(16'h0F0F, 16'hF0F0, CLEAN_BCLKS, 1'b1);
    checkOutput("recover");

    // Pad bits beyond the word are ignored
    applyStimulus(16'h7FFF, 16'h0F0F, PAD_BCLKS, 1'b1);
    checkOutput("pad");

    // Mixing corner cases (plain left pass-through when mixing is off)
    applyStimulus(16'h7FFF, 16'h7FFF, CLEAN_BCLKS, 1'b1);
    checkOutput("mix_max");
    applyStimulus(16'h8000, 16'h8000, CLEAN_BCLKS, 1'b1);
    checkOutput("mix_min");
    applyStimulus(16'h0001, 16'hFFFF, CLEAN_BCLKS, 1'b1);
    checkOutput("mix_cancel");
    applyStimulus(16'h0001, 16'h0000, CLEAN_BCLKS, 1'b1);
    checkOutput("mix_round");

    // Reset pulsed in the middle of a right word
    $display("[TB] reset mid right word");
    send_channel(CH_LEFT, 16'hCAFE, DATA_W, CLEAN_BCLKS, 1'b0);
    send_channel(CH_RIGHT, 16'hBEEF, 8, 9, 1'b0);
    reset_n     = 1'b0;
    aud_adclrck = 1'b0;
    aud_bclk    = 1'b0;
    aud_adcdat  = 1'b0;
    @(negedge clk);
    chk("midreset_out_port", 32'(out_port), 32'h0);
    chk("midreset_right_sample", 32'(right_sample), 32'h0);
    repeat (5) @(negedge clk);
    reset_n    = 1'b1;
    held_out   = '0;
    held_right = '0;
    repeat (4) @(negedge clk);
    applyStimulus(16'h4321, 16'h8765, CLEAN_BCLKS, 1'b0);
    checkOutput("post_reset_first");
    applyStimulus(16'h2468, 16'h1357, CLEAN_BCLKS, 1'b1);
    checkOutput("post_reset_second");

    chk("final_err_pulses", 32'(err_seen), 32'(exp_err));
    chk("single_cycle_valid", 32'(dbl_seen), 32'd0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
